// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
//   Sequential execute stage. Takes OperandA from the register file and
//   OperandB from the operand-B mux, then produces a registered Result along
//   with the Carry and Zero flags.
//   - ADD, SUB, AND, OR, XOR, SHL and SHR complete on the accept edge, so
//     their result is visible one cycle later.
//   - MUL runs as a WIDTH-step shift-add sequence. busy is high while it is
//     in flight.
//   - done pulses for one cycle on every edge that writes Result and flags.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-high reset
//   start     in   request; accepted only on an edge where busy=0
//   ALUop     in   3-bit operation code (ADD,SUB,AND,OR,XOR,MUL,SHL,SHR)
//   OperandA  in   WIDTH-bit first operand
//   OperandB  in   WIDTH-bit second operand
//   Result    out  WIDTH-bit registered result
//   Carry     out  registered carry / no-borrow / multiply-overflow flag
//   Zero      out  registered flag, set when the new Result is zero
//   busy      out  high while a multiply is in progress
//   done      out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       ALUop,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  output logic [WIDTH-1:0] Result,
  output logic             Carry,
  output logic             Zero,
  output logic             busy,
  output logic             done
);

  localparam int SHW = $clog2(WIDTH);     // shift-amount width
  localparam int CW  = $clog2(WIDTH) + 1; // counter must be able to hold WIDTH

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_MUL = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } alu_op_e;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_e;

  state_e             r_state;
  state_e             w_state_next;
  logic               w_busy;
  logic               w_accept;
  alu_op_e            w_op;

  // Registered outputs
  logic [WIDTH-1:0]   r_result;
  logic               r_carry;
  logic               r_zero;
  logic               r_done;

  // Multiply datapath
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] w_acc_next;
  logic               w_mul_last;

  // Single-cycle ALU
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_alu_result;
  logic               w_alu_carry;

  assign w_op       = alu_op_e'(ALUop);
  assign w_accept   = start & ~w_busy;
  assign w_mul_last = (r_count == CW'(1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked process uses non-blocking (<=) assignments, so all
  // registers update together from pre-edge values, whatever the order in
  // which the processes are evaluated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: each combinational process assigns a default to every output first,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept && (w_op == OP_MUL)) w_state_next = S_MUL;
      S_MUL:   if (w_mul_last)                   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_busy = 1'b0;
    if (r_state == S_MUL) w_busy = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Single-cycle operations, evaluated on the operands present at the accept
  // edge.
  // ---------------------------------------------------------------------------
  assign w_sum = {1'b0, OperandA} + {1'b0, OperandB};

  always_comb begin
    w_alu_result = '0;
    w_alu_carry  = 1'b0;
    unique case (w_op)
      OP_ADD: begin
        w_alu_result = w_sum[WIDTH-1:0];
        w_alu_carry  = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_alu_result = OperandA - OperandB;
        w_alu_carry  = (OperandA >= OperandB); // set when there is no borrow
      end
      OP_AND: w_alu_result = OperandA & OperandB;
      OP_OR:  w_alu_result = OperandA | OperandB;
      OP_XOR: w_alu_result = OperandA ^ OperandB;
      // Shift amount is B modulo WIDTH. Only the low log2(WIDTH) bits are used.
      OP_SHL: w_alu_result = OperandA << OperandB[SHW-1:0];
      OP_SHR: w_alu_result = OperandA >> OperandB[SHW-1:0];
      OP_MUL: w_alu_result = '0; // handled by the multi-cycle path
      default: begin
        w_alu_result = '0;
        w_alu_carry  = 1'b0;
      end
    endcase
  end

  // One shift-add step. The final step's sum feeds Result directly, so the
  // completion edge already includes the last partial product.
  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_done   <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        if (w_op == OP_MUL) begin
          r_acc    <= '0;
          r_mcand  <= {{WIDTH{1'b0}}, OperandA};
          r_mplier <= OperandB;
          r_count  <= CW'(WIDTH);
        end else begin
          r_result <= w_alu_result;
          r_carry  <= w_alu_carry;
          r_zero   <= (w_alu_result == '0);
          r_done   <= 1'b1;
        end
      end else if (r_state == S_MUL) begin
        r_acc    <= w_acc_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_count  <= r_count - CW'(1);
        if (w_mul_last) begin
          r_result <= w_acc_next[WIDTH-1:0];
          r_carry  <= |w_acc_next[2*WIDTH-1:WIDTH]; // product overflowed WIDTH
          r_zero   <= (w_acc_next[WIDTH-1:0] == '0);
          r_done   <= 1'b1;
        end
      end
    end
  end

  assign Result = r_result;
  assign Carry  = r_carry;
  assign Zero   = r_zero;
  assign busy   = w_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu
//   Self-checking bench for seq_alu with WIDTH=8. A table of directed vectors
//   is issued back to back. Hand-written sequences then cover a start request
//   during a multiply, an asynchronous reset mid-multiply, and Result holding
//   its value while idle.
// -----------------------------------------------------------------------------
module tb_seq_alu;

  localparam int W = 8;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] AND = 3'b010;
  localparam logic [2:0] OR  = 3'b011;
  localparam logic [2:0] XOR = 3'b100;
  localparam logic [2:0] MUL = 3'b101;
  localparam logic [2:0] SHL = 3'b110;
  localparam logic [2:0] SHR = 3'b111;

  logic         clk;
  logic         reset;
  logic         start;
  logic [2:0]   ALUop;
  logic [W-1:0] OperandA;
  logic [W-1:0] OperandB;
  logic [W-1:0] Result;
  logic         Carry;
  logic         Zero;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         c;
    logic         z;
  } vec_t;

  vec_t vecs[16];

  seq_alu #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .ALUop    (ALUop),
    .OperandA (OperandA),
    .OperandB (OperandB),
    .Result   (Result),
    .Carry    (Carry),
    .Zero     (Zero),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one operation on the next rising edge, then check its completion.
  // For MUL, also check busy/done throughout the WIDTH-cycle run.
  task automatic run_vec(input vec_t v, input string tag);
    logic bad;
    @(negedge clk);
    start    = 1'b1;
    ALUop    = v.op;
    OperandA = v.a;
    OperandB = v.b;
    @(posedge clk); #1;  // accept edge T0
    if (v.op == MUL) begin
      check({tag, " busy_after_accept"}, busy, 1);
      check({tag, " no_done_at_accept"}, done, 0);
      start    = 1'b0;
      OperandA = ~v.a;   // operands must already be latched
      OperandB = ~v.b;
      bad = 1'b0;
      for (int k = 1; k < W; k++) begin
        @(posedge clk); #1;
        if (busy !== 1'b1 || done !== 1'b0) bad = 1'b1;
      end
      check({tag, " busy_window"}, bad, 0);
      @(posedge clk); #1;  // edge T0+W
      check({tag, " busy_fall"}, busy, 0);
    end
    check({tag, " done"},   done,   1);
    check({tag, " result"}, Result, v.res);
    check({tag, " carry"},  Carry,  v.c);
    check({tag, " zero"},   Zero,   v.z);
  endtask

  initial begin
    int done_cnt;
    int done_edge;

    // ---------------- vector table ----------------
    vecs[0]  = '{ADD, 8'd200, 8'd100, 8'd44,  1'b1, 1'b0};
    vecs[1]  = '{SUB, 8'd5,   8'd7,   8'd254, 1'b0, 1'b0};
    vecs[2]  = '{SUB, 8'd7,   8'd7,   8'd0,   1'b1, 1'b1};
    vecs[3]  = '{MUL, 8'd13,  8'd11,  8'd143, 1'b0, 1'b0};
    vecs[4]  = '{MUL, 8'd20,  8'd20,  8'd144, 1'b1, 1'b0};
    vecs[5]  = '{SHL, 8'h81,  8'd9,   8'h02,  1'b0, 1'b0};
    vecs[6]  = '{SHR, 8'h81,  8'd7,   8'h01,  1'b0, 1'b0};
    vecs[7]  = '{XOR, 8'hAA,  8'hAA,  8'h00,  1'b0, 1'b1};
    vecs[8]  = '{OR,  8'h0F,  8'hF0,  8'hFF,  1'b0, 1'b0};
    vecs[9]  = '{ADD, 8'hFF,  8'h01,  8'h00,  1'b1, 1'b1};
    vecs[10] = '{MUL, 8'd255, 8'd255, 8'h01,  1'b1, 1'b0};
    vecs[11] = '{SHL, 8'h01,  8'd7,   8'h80,  1'b0, 1'b0};
    vecs[12] = '{SHR, 8'h80,  8'd8,   8'h80,  1'b0, 1'b0};
    vecs[13] = '{MUL, 8'd0,   8'd77,  8'd0,   1'b0, 1'b1};
    vecs[14] = '{MUL, 8'd16,  8'd16,  8'd0,   1'b1, 1'b1};
    vecs[15] = '{AND, 8'hF0,  8'h3C,  8'h30,  1'b0, 1'b0};

    // ---------------- reset state ----------------
    reset = 1'b0; start = 1'b0; ALUop = ADD; OperandA = '0; OperandB = '0;
    #1 reset = 1'b1;
    #2;
    check("rst result", Result, 0);
    check("rst carry",  Carry,  0);
    check("rst zero",   Zero,   0);
    check("rst busy",   busy,   0);
    check("rst done",   done,   0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // ---------------- table, issued back to back ----------------
    for (int i = 0; i < 16; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // done is a single pulse; Result/flags hold while idle
    @(negedge clk) start = 1'b0;
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    repeat (3) @(posedge clk); #1;
    check("hold result", Result, 8'h30);
    check("hold zero",   Zero,   0);

    // ---------------- start during MUL is ignored ----------------
    @(negedge clk);
    start = 1'b1; ALUop = MUL; OperandA = 8'd3; OperandB = 8'd5;
    @(posedge clk); #1;  // T0
    start = 1'b0;
    done_cnt  = 0;
    done_edge = -1;
    for (int cyc = 1; cyc <= W + 6; cyc++) begin
      @(negedge clk);
      if (cyc == 3) begin
        start = 1'b1; ALUop = ADD; OperandA = 8'd1; OperandB = 8'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done === 1'b1) begin
        done_cnt++;
        done_edge = cyc;
      end
    end
    check("ign done_count", done_cnt,  1);
    check("ign done_edge",  done_edge, W);
    check("ign result",     Result,    15);
    check("ign carry",      Carry,     0);

    // ---------------- async reset mid-MUL ----------------
    @(negedge clk);
    start = 1'b1; ALUop = MUL; OperandA = 8'd13; OperandB = 8'd11;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3 reset = 1'b1;     // between clock edges
    #1;
    check("arst result", Result, 0);
    check("arst carry",  Carry,  0);
    check("arst zero",   Zero,   0);
    check("arst busy",   busy,   0);
    check("arst done",   done,   0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    done_cnt = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) done_cnt++;
    end
    check("arst no_late_done", done_cnt, 0);
    run_vec(vecs[15], "post_reset_and");

    @(negedge clk) start = 1'b0;
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Sequential execute stage that consumes `OperandA` from the register file and `OperandB` from the operand-B select mux, then produces a registered result with status flags. Logic, add/subtract and shift operations complete in one cycle. Multiply runs as a multi-cycle shift-add sequence. A start/busy/done handshake lets the control FSM issue operations back to back.

## Interface
- `WIDTH`, default 8: datapath width. Must be a power of two in 4..32.
- `clk`  in  1  rising-edge clock; the block's only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request. Accepted only on an edge where `busy`=0.
- `ALUop`  in  3  operation code: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL, 110 SHL, 111 SHR.
- `OperandA`  in  WIDTH  first operand.
- `OperandB`  in  WIDTH  second operand, driven by the operand-B mux.
- `Result`  out  WIDTH  registered result. Holds its value until the next completion.
- `Carry`  out  1  registered carry/overflow flag.
- `Zero`  out  1  registered flag; 1 when `Result`==0.
- `busy`  out  1  high while a multiply is in progress.
- `done`  out  1  one-cycle pulse when `Result` and the flags update.

## Operation
- States:
  - IDLE: accepts requests.
  - MUL: iterates the multiply.
- Accept edge: an edge where `start`=1 and `busy`=0. On that edge `OperandA`, `OperandB` and `ALUop` are latched. Operands are not sampled again during the operation.
- Non-MUL ops, computed in the accept edge itself; state stays IDLE:
  - ADD: `Result`=(A+B) mod 2^WIDTH. `Carry`=carry out.
  - SUB: `Result`=(A−B) mod 2^WIDTH. `Carry`=1 iff A≥B (no borrow).
  - AND / OR / XOR: bitwise. `Carry`=0.
  - SHL / SHR: logical shift of A by B[log2(WIDTH)-1:0]; B modulo WIDTH. Zero fill. `Carry`=0.
- MUL, entered from IDLE on the accept edge:
  - Load multiplicand=A, multiplier=B, 2·WIDTH-bit accumulator=0, counter=WIDTH. Enter MUL.
  - On each MUL edge: if the multiplier LSB is 1, add the shifted multiplicand into the accumulator. Shift the multiplier right and the multiplicand left. Decrement the counter.
  - On the edge where the counter goes 1→0: `Result`=accumulator low WIDTH bits. `Carry`=1 iff the high WIDTH bits ≠ 0 (overflow). Return to IDLE.
- `Zero` is always derived from the newly written `Result`.
- `start` while `busy`=1 is ignored: no queueing, no effect on the in-flight op.
- Undefined `ALUop` values: none; all 8 codes are legal.

## Timing
- Reset (asynchronous assert, any state):
  - `Result`=0, `Carry`=0, `Zero`=0, `busy`=0, `done`=0.
  - State=IDLE. Any in-flight multiply is discarded.
- Release of `reset` is synchronous to `clk`. The first accept can occur on the first edge after deassertion.
- Non-MUL latency: `Result`, the flags and `done`=1 are visible in the cycle after the accept edge (1 cycle).
- MUL latency:
  - Accept edge T0; `busy`=1 from after T0 until edge T0+WIDTH.
  - `Result` and `done`=1 are visible after edge T0+WIDTH, the same edge where `busy` falls.
- `done` is high for exactly one cycle per accepted request.
- Back to back: `start` in the `done` cycle is accepted (`busy`=0). Issue rate is 1/cycle for non-MUL ops and 1 per WIDTH cycles for MUL.
- `Result` and the flags never change except on a completion edge or on reset.

## Test plan
- Reset, then ADD A=200, B=100 (WIDTH=8) -> one cycle later: `Result`=44, `Carry`=1, `Zero`=0, `done` pulse of 1 cycle.
- SUB A=5, B=7 -> `Result`=254, `Carry`=0. Then SUB 7,7 issued in the `done` cycle -> `Result`=0, `Zero`=1, `Carry`=1 on the next cycle.
- MUL A=13, B=11 -> `busy` high 8 cycles, then `Result`=143, `Carry`=0, `done` exactly at edge T0+8. MUL 20×20 -> `Result`=144, `Carry`=1.
- During MUL 3×5, pulse `start` with ADD 1+1 at busy cycle 3 -> ignored. Final `Result`=15, exactly one `done`, no later pulse.
- Assert `reset` asynchronously mid-clock at busy cycle 4 of a MUL -> all outputs 0 immediately, no `done`. After release, AND 0xF0, 0x3C -> `Result`=0x30.
- SHL A=0x81, B=9 -> `Result`=0x02. SHR A=0x81, B=7 -> `Result`=0x01. XOR 0xAA, 0xAA -> `Zero`=1.
